// File: rtl/mdu_unit_if.sv
// Multiply/divide unit E-stage bus: issue fields in, busy/readback out.
// HI/LO are exposed so forwarding and debug can observe them directly.
interface mdu_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, rd_data, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, rd_data, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// MIPS multiply/divide unit owning HI/LO; results are computed at issue
// and held pending until a fixed-latency countdown commits them.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset_n,
    mdu_unit_if.slave bus
);

    localparam int MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo;

    assign is_mult  = (bus.op == OP_MULT);
    assign is_multu = (bus.op == OP_MULTU);
    assign is_div   = (bus.op == OP_DIV);
    assign is_divu  = (bus.op == OP_DIVU);
    assign is_mfhi  = (bus.op == OP_MFHI);
    assign is_mflo  = (bus.op == OP_MFLO);
    assign is_mthi  = (bus.op == OP_MTHI);
    assign is_mtlo  = (bus.op == OP_MTLO);

    // Datapath: all four results are formed from a/b at the issue edge.
    logic [63:0] smul, umul;
    logic        b_nz;
    logic [31:0] dvs;
    logic [31:0] abs_a, abs_b;
    logic [31:0] sq_mag, sr_mag;
    logic [31:0] sq, sr;
    logic [31:0] uq, ur;

    always_comb begin
        smul  = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        umul  = {32'b0, bus.a} * {32'b0, bus.b};
        b_nz  = (bus.b != 32'd0);
        // Divisor forced to 1 on b==0 so no divide-by-zero reaches the divider.
        dvs   = b_nz ? bus.b : 32'd1;
        abs_a = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
        abs_b = dvs[31] ? (~dvs + 32'd1) : dvs;
        sq_mag = abs_a / abs_b;
        sr_mag = abs_a % abs_b;
        sq = (bus.a[31] ^ dvs[31]) ? (~sq_mag + 32'd1) : sq_mag;
        sr = bus.a[31] ? (~sr_mag + 32'd1) : sr_mag;
        uq = bus.a / dvs;
        ur = bus.a % dvs;
    end

    always_comb begin
        state = (cnt_q != '0) ? RUN : IDLE;
    end

    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    unique case (1'b1)
                        is_mult: begin
                            cnt_d     = CW'(MULT_CYCLES);
                            pend_hi_d = smul[63:32];
                            pend_lo_d = smul[31:0];
                        end
                        is_multu: begin
                            cnt_d     = CW'(MULT_CYCLES);
                            pend_hi_d = umul[63:32];
                            pend_lo_d = umul[31:0];
                        end
                        is_div: begin
                            cnt_d     = CW'(DIV_CYCLES);
                            pend_hi_d = b_nz ? sr : hi_q;
                            pend_lo_d = b_nz ? sq : lo_q;
                        end
                        is_divu: begin
                            cnt_d     = CW'(DIV_CYCLES);
                            pend_hi_d = b_nz ? ur : hi_q;
                            pend_lo_d = b_nz ? uq : lo_q;
                        end
                        is_mthi: hi_d = bus.a;
                        is_mtlo: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        bus.rd_data = 32'd0;
        unique case (1'b1)
            is_mfhi: bus.rd_data = hi_q;
            is_mflo: bus.rd_data = lo_q;
            default: ;
        endcase
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // The hazard unit must hold D while busy; a real op here is a stall bug.
    a_no_issue_busy: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(bus.start && bus.busy && (bus.op >= OP_MULT) && (bus.op <= OP_MTLO))
    ) else $warning("mdu_unit: op %0d issued while busy, ignored", bus.op);

endmodule
